// File: rtl/mac_accum_pkg.sv
// mac_accum_pkg: shared definitions for the MAC result accumulator slice.
//   - default widths for the partial product, accumulator and beat counter
//   - group-accumulation state enum
//   - saturation limit helpers (two's complement bounds for a given width,
//     returned in 64 bits; callers truncate to their accumulator width)
package mac_accum_pkg;

  localparam int DEF_IN_W  = 32;
  localparam int DEF_ACC_W = 32;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,  // accumulator empty, next beat starts a group
    ST_ACCUM = 1'b1   // at least one beat summed, ilast not yet seen
  } state_t;

  // Largest positive value representable in w-bit two's complement.
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative value representable in w-bit two's complement.
  function automatic logic [63:0] sat_min(input int w);
    return ~sat_max(w);
  endfunction

endpackage

// File: rtl/mac_accum_outreg.sv
// mac_accum_outreg: one-entry output holding register with valid/ready.
//   clock, resetn      : clock, asynchronous active-low reset
//   load               : a finished group sum is presented this cycle
//   load_result/count/sat : values captured when load is high
//   iready             : downstream accepts the held result
//   oready             : register can take a new group this cycle
//                        (empty, or being drained in the same cycle)
//   ovalid, result, count, osat : registered result; stable while
//                        ovalid && !iready
module mac_accum_outreg #(
  parameter int ACC_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             load,
  input  logic [ACC_W-1:0] load_result,
  input  logic [CNT_W-1:0] load_count,
  input  logic             load_sat,
  input  logic             iready,
  output logic             oready,
  output logic             ovalid,
  output logic [ACC_W-1:0] result,
  output logic [CNT_W-1:0] count,
  output logic             osat
);

  logic             valid_r;
  logic [ACC_W-1:0] result_r;
  logic [CNT_W-1:0] count_r;
  logic             sat_r;

  // Accept a new group when empty or when the held one leaves this cycle.
  always_comb begin
    oready = !valid_r || iready;
  end

  // Holding register: load has priority, drain clears valid, else hold.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      valid_r  <= 1'b0;
      result_r <= '0;
      count_r  <= '0;
      sat_r    <= 1'b0;
    end else if (load) begin
      valid_r  <= 1'b1;
      result_r <= load_result;
      count_r  <= load_count;
      sat_r    <= load_sat;
    end else if (iready) begin
      valid_r  <= 1'b0;
    end else begin
      valid_r  <= valid_r;
    end
  end

  assign ovalid = valid_r;
  assign result = result_r;
  assign count  = count_r;
  assign osat   = sat_r;

endmodule

// File: rtl/mac_result_accumulator.sv
// mac_result_accumulator: sums signed MAC partial products over a group of
// beats terminated by ilast and presents the group sum with its beat count.
//   clock, resetn     : clock, asynchronous active-low reset
//   ivalid/oready     : beat handshake (idata signed partial product, ilast)
//   ovalid/iready     : result handshake
//   result            : signed group sum, count: beats in that group
//   osat              : group result clamped at least once
// Optional feature macro MAC_ACCUM_SATURATE_EN: when defined every add
// saturates to the ACC_W signed range and osat reports a clamp in the
// group; when undefined adds wrap and osat is constant 0.
module mac_result_accumulator
  import mac_accum_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             ivalid,
  output logic             oready,
  input  logic [IN_W-1:0]  idata,
  input  logic             ilast,
  output logic             ovalid,
  input  logic             iready,
  output logic [ACC_W-1:0] result,
  output logic [CNT_W-1:0] count,
  output logic             osat
);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [ACC_W-1:0] acc_r;
  logic [CNT_W-1:0] cnt_r;
  logic [ACC_W-1:0] acc_base_s;
  logic [CNT_W-1:0] cnt_base_s;
  logic [ACC_W-1:0] idata_ext_s;
  logic [ACC_W-1:0] sum_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             grp_sat_s;
  logic             beat_s;
  logic             group_done_s;

  assign beat_s       = ivalid & oready;
  assign group_done_s = beat_s & ilast;
  assign idata_ext_s  = ACC_W'($signed(idata));

  // A new group starts from zero; otherwise continue from the running sum.
  always_comb begin
    acc_base_s = '0;
    cnt_base_s = '0;
    if (state_r == ST_ACCUM) begin
      acc_base_s = acc_r;
      cnt_base_s = cnt_r;
    end else begin
      acc_base_s = '0;
      cnt_base_s = '0;
    end
  end

  // Beat counter sticks at all-ones; beats past that are still summed.
  always_comb begin
    cnt_inc_s = cnt_base_s;
    if (&cnt_base_s) begin
      cnt_inc_s = cnt_base_s;
    end else begin
      cnt_inc_s = cnt_base_s + CNT_W'(1);
    end
  end

`ifdef MAC_ACCUM_SATURATE_EN
  localparam logic [ACC_W-1:0] SAT_MAX = ACC_W'(sat_max(ACC_W));
  localparam logic [ACC_W-1:0] SAT_MIN = ACC_W'(sat_min(ACC_W));

  logic [ACC_W:0] sum_wide_s;
  logic           clamp_s;
  logic           sat_r;

  // One guard bit: overflow when the true sign differs from the ACC_W sign.
  always_comb begin
    sum_wide_s = {acc_base_s[ACC_W-1], acc_base_s}
               + {idata_ext_s[ACC_W-1], idata_ext_s};
    clamp_s    = sum_wide_s[ACC_W] ^ sum_wide_s[ACC_W-1];
    sum_s      = sum_wide_s[ACC_W-1:0];
    if (clamp_s) begin
      sum_s = sum_wide_s[ACC_W] ? SAT_MIN : SAT_MAX;
    end else begin
      sum_s = sum_wide_s[ACC_W-1:0];
    end
    grp_sat_s = clamp_s | ((state_r == ST_ACCUM) & sat_r);
  end

  // Sticky clamp flag for the group in progress.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sat_r <= 1'b0;
    end else if (group_done_s) begin
      sat_r <= 1'b0;
    end else if (beat_s) begin
      sat_r <= grp_sat_s;
    end else begin
      sat_r <= sat_r;
    end
  end
`else
  // Plain modulo-2^ACC_W accumulation.
  always_comb begin
    sum_s     = acc_base_s + idata_ext_s;
    grp_sat_s = 1'b0;
  end
`endif

  // Next state: ilast closes the group, any other beat keeps accumulating.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_ACCUM: begin
        if (beat_s) begin
          state_nxt_s = ilast ? ST_IDLE : ST_ACCUM;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Running sum and beat count; cleared once the group is handed off.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      acc_r <= '0;
      cnt_r <= '0;
    end else if (group_done_s) begin
      acc_r <= '0;
      cnt_r <= '0;
    end else if (beat_s) begin
      acc_r <= sum_s;
      cnt_r <= cnt_inc_s;
    end else begin
      acc_r <= acc_r;
      cnt_r <= cnt_r;
    end
  end

  mac_accum_outreg #(
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) u_outreg (
    .clock       (clock),
    .resetn      (resetn),
    .load        (group_done_s),
    .load_result (sum_s),
    .load_count  (cnt_inc_s),
    .load_sat    (grp_sat_s),
    .iready      (iready),
    .oready      (oready),
    .ovalid      (ovalid),
    .result      (result),
    .count       (count),
    .osat        (osat)
  );

endmodule

// File: tb/tb_mac_result_accumulator.sv
// Directed self-checking bench for mac_result_accumulator (default widths).
// Expected saturation behaviour follows MAC_ACCUM_SATURATE_EN when defined.
module tb_mac_result_accumulator;

  localparam int IN_W  = 32;
  localparam int ACC_W = 32;
  localparam int CNT_W = 16;

  logic             clock = 1'b0;
  logic             resetn = 1'b0;
  logic             ivalid = 1'b0;
  logic             oready;
  logic [IN_W-1:0]  idata = '0;
  logic             ilast = 1'b0;
  logic             ovalid;
  logic             iready = 1'b0;
  logic [ACC_W-1:0] result;
  logic [CNT_W-1:0] count;
  logic             osat;

  int vectors = 0;
  int miscompares = 0;

  mac_result_accumulator #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .resetn(resetn), .ivalid(ivalid), .oready(oready),
    .idata(idata), .ilast(ilast), .ovalid(ovalid), .iready(iready),
    .result(result), .count(count), .osat(osat)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic beat(input logic [IN_W-1:0] d, input logic l);
    ivalid = 1'b1; idata = d; ilast = l;
    tick();
    ivalid = 1'b0; idata = '0; ilast = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; iready = 1'b0;
    #2;
    vectors++; if (ovalid !== 1'b0) begin miscompares++; $display("FAIL rst_ovalid: got %b want 0", ovalid); end
    vectors++; if (result !== 32'h0) begin miscompares++; $display("FAIL rst_result: got %h want 0", result); end
    vectors++; if (count !== 16'h0) begin miscompares++; $display("FAIL rst_count: got %h want 0", count); end
    vectors++; if (osat !== 1'b0) begin miscompares++; $display("FAIL rst_osat: got %b want 0", osat); end
    vectors++; if (oready !== 1'b1) begin miscompares++; $display("FAIL rst_oready: got %b want 1", oready); end
    tick(); tick();
    resetn = 1'b1;
    tick();
    vectors++; if (oready !== 1'b1) begin miscompares++; $display("FAIL post_rst_oready: got %b want 1", oready); end
    vectors++; if (ovalid !== 1'b0) begin miscompares++; $display("FAIL post_rst_ovalid: got %b want 0", ovalid); end
  endtask

  task automatic test_sum();
    iready = 1'b1;
    beat(32'd3, 1'b0);
    beat(32'd5, 1'b0);
    vectors++; if (ovalid !== 1'b0) begin miscompares++; $display("FAIL sum_early_ovalid: got %b want 0", ovalid); end
    beat(-32'sd2, 1'b1);
    vectors++; if (ovalid !== 1'b1) begin miscompares++; $display("FAIL sum_ovalid: got %b want 1", ovalid); end
    vectors++; if (result !== 32'd6) begin miscompares++; $display("FAIL sum_result: got %h want 6", result); end
    vectors++; if (count !== 16'd3) begin miscompares++; $display("FAIL sum_count: got %0d want 3", count); end
    vectors++; if (osat !== 1'b0) begin miscompares++; $display("FAIL sum_osat: got %b want 0", osat); end
    tick();
    vectors++; if (ovalid !== 1'b0) begin miscompares++; $display("FAIL sum_drain: got %b want 0", ovalid); end
  endtask

  task automatic test_hold();
    iready = 1'b0;
    beat(32'd100, 1'b1);
    for (int i = 0; i < 4; i++) begin
      vectors++; if (ovalid !== 1'b1) begin miscompares++; $display("FAIL hold_ovalid[%0d]: got %b want 1", i, ovalid); end
      vectors++; if (result !== 32'd100) begin miscompares++; $display("FAIL hold_result[%0d]: got %h want 64", i, result); end
      vectors++; if (count !== 16'd1) begin miscompares++; $display("FAIL hold_count[%0d]: got %0d want 1", i, count); end
      vectors++; if (oready !== 1'b0) begin miscompares++; $display("FAIL hold_oready[%0d]: got %b want 0", i, oready); end
      tick();
    end
    iready = 1'b1;
    #1;
    vectors++; if (oready !== 1'b1) begin miscompares++; $display("FAIL hold_release_oready: got %b want 1", oready); end
    tick();
    vectors++; if (ovalid !== 1'b0) begin miscompares++; $display("FAIL hold_drained: got %b want 0", ovalid); end
  endtask

  task automatic test_back_to_back();
    iready = 1'b1;
    ivalid = 1'b1; ilast = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      idata = IN_W'(i);
      vectors++; if (oready !== 1'b1) begin miscompares++; $display("FAIL b2b_oready[%0d]: got %b want 1", i, oready); end
      tick();
      vectors++; if (ovalid !== 1'b1) begin miscompares++; $display("FAIL b2b_ovalid[%0d]: got %b want 1", i, ovalid); end
      vectors++; if (result !== ACC_W'(i)) begin miscompares++; $display("FAIL b2b_result[%0d]: got %h want %h", i, result, ACC_W'(i)); end
      vectors++; if (count !== 16'd1) begin miscompares++; $display("FAIL b2b_count[%0d]: got %0d want 1", i, count); end
    end
    ivalid = 1'b0; ilast = 1'b0; idata = '0;
    tick();
    vectors++; if (ovalid !== 1'b0) begin miscompares++; $display("FAIL b2b_drain: got %b want 0", ovalid); end
  endtask

  task automatic test_idle_gap();
    iready = 1'b1;
    ivalid = 1'b0; ilast = 1'b1; idata = 32'd999;
    tick(); tick(); tick();
    vectors++; if (ovalid !== 1'b0) begin miscompares++; $display("FAIL gap_no_output: got %b want 0", ovalid); end
    ilast = 1'b0;
    beat(32'd2, 1'b0);
    idata = 32'd50;
    tick(); tick();
    beat(32'd3, 1'b1);
    vectors++; if (result !== 32'd5) begin miscompares++; $display("FAIL gap_result: got %h want 5", result); end
    vectors++; if (count !== 16'd2) begin miscompares++; $display("FAIL gap_count: got %0d want 2", count); end
    tick();
  endtask

  task automatic test_saturate();
    logic [ACC_W-1:0] exp_pos, exp_neg, exp_mid;
    logic             exp_sat;
`ifdef MAC_ACCUM_SATURATE_EN
    exp_pos = 32'h7FFF_FFFF; exp_neg = 32'h8000_0000; exp_mid = 32'h7FFF_FFEB; exp_sat = 1'b1;
`else
    exp_pos = 32'h8000_0000; exp_neg = 32'h7FFF_FFFF; exp_mid = 32'h7FFF_FFF5; exp_sat = 1'b0;
`endif
    iready = 1'b1;
    beat(32'h7FFF_FFFF, 1'b0);
    beat(32'd1, 1'b1);
    vectors++; if (result !== exp_pos) begin miscompares++; $display("FAIL sat_pos_result: got %h want %h", result, exp_pos); end
    vectors++; if (osat !== exp_sat) begin miscompares++; $display("FAIL sat_pos_osat: got %b want %b", osat, exp_sat); end
    beat(32'h8000_0000, 1'b0);
    beat(32'hFFFF_FFFF, 1'b1);
    vectors++; if (result !== exp_neg) begin miscompares++; $display("FAIL sat_neg_result: got %h want %h", result, exp_neg); end
    vectors++; if (osat !== exp_sat) begin miscompares++; $display("FAIL sat_neg_osat: got %b want %b", osat, exp_sat); end
    beat(32'd5, 1'b1);
    vectors++; if (result !== 32'd5) begin miscompares++; $display("FAIL sat_clear_result: got %h want 5", result); end
    vectors++; if (osat !== 1'b0) begin miscompares++; $display("FAIL sat_clear_osat: got %b want 0", osat); end
    beat(32'h7FFF_FFFF, 1'b0);
    beat(32'd10, 1'b0);
    beat(-32'sd20, 1'b1);
    vectors++; if (result !== exp_mid) begin miscompares++; $display("FAIL sat_sticky_result: got %h want %h", result, exp_mid); end
    vectors++; if (osat !== exp_sat) begin miscompares++; $display("FAIL sat_sticky_osat: got %b want %b", osat, exp_sat); end
    vectors++; if (count !== 16'd3) begin miscompares++; $display("FAIL sat_sticky_count: got %0d want 3", count); end
    tick();
  endtask

  task automatic test_reset_mid();
    iready = 1'b0;
    beat(32'd9, 1'b1);
    vectors++; if (ovalid !== 1'b1) begin miscompares++; $display("FAIL rmid_unread_ovalid: got %b want 1", ovalid); end
    resetn = 1'b0;
    #2;
    vectors++; if (ovalid !== 1'b0) begin miscompares++; $display("FAIL rmid_discard_ovalid: got %b want 0", ovalid); end
    tick();
    resetn = 1'b1; iready = 1'b1;
    beat(32'd7, 1'b0);
    beat(32'd7, 1'b0);
    resetn = 1'b0;
    #2;
    vectors++; if (oready !== 1'b1) begin miscompares++; $display("FAIL rmid_oready: got %b want 1", oready); end
    tick();
    resetn = 1'b1;
    tick(); tick();
    vectors++; if (ovalid !== 1'b0) begin miscompares++; $display("FAIL rmid_no_output: got %b want 0", ovalid); end
    beat(32'd4, 1'b1);
    vectors++; if (ovalid !== 1'b1) begin miscompares++; $display("FAIL rmid_ovalid: got %b want 1", ovalid); end
    vectors++; if (result !== 32'd4) begin miscompares++; $display("FAIL rmid_result: got %h want 4", result); end
    vectors++; if (count !== 16'd1) begin miscompares++; $display("FAIL rmid_count: got %0d want 1", count); end
    tick();
  endtask

  task automatic test_count_sat();
    iready = 1'b1;
    ivalid = 1'b1; ilast = 1'b0; idata = 32'd1;
    repeat (65536) tick();
    ilast = 1'b1;
    tick();
    ivalid = 1'b0; ilast = 1'b0; idata = '0;
    vectors++; if (count !== 16'hFFFF) begin miscompares++; $display("FAIL cnt_sat_count: got %h want ffff", count); end
    vectors++; if (result !== 32'd65537) begin miscompares++; $display("FAIL cnt_sat_result: got %0d want 65537", result); end
    tick();
  endtask

  initial begin
    test_reset();
    test_sum();
    test_hold();
    test_back_to_back();
    test_idle_gap();
    test_saturate();
    test_reset_mid();
    test_count_sat();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
